// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed data memory behind a fixed-latency
// handshake. Each load/store holds the pipeline for LATENCY+1 cycles
// (IDLE request cycle plus LATENCY WAIT cycles). The access happens on the
// WAIT edge where the counter reaches zero, and the pipeline releases in DONE.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag byte addresses whose
// upper bits fall outside the array. In that case the access is suppressed
// and a sticky err_o is raised. Without it, upper bits alias and err_o is 0.
module data_memory_ctrl #(
  parameter int LATENCY = 2,   // 1..15
  parameter int ADDR_W  = 6    // word-address width
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                op_wr_reg, op_rd_reg;
  logic [31:0]         rdata_reg;
  logic [31:0]         mem [0:DEPTH-1];

  logic                req;
  logic                access;
  logic                range_ok;
  logic                do_write;
  logic                do_read;
  logic [ADDR_W-1:0]   index;
  logic                unused_addr_bits;

  assign req   = MemRead_i | MemWrite_i;
  assign index = addr_i[ADDR_W+1:2];
  // Byte-lane bits are never used, and the upper bits are only used with range checking.
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  logic err_reg;
  assign range_ok = (addr_i[31:ADDR_W+2] == '0);
  assign err_o    = err_reg;
`else
  assign range_ok = 1'b1;
  assign err_o    = 1'b0;
`endif

  // The access edge is the last WAIT edge. Reset kills it even on a coincident edge.
  assign access   = (state_reg == WAIT) && (cnt_reg == 4'd0) && !rst_i;
  // A combined read+write request acts as a write only.
  assign do_write = access && op_wr_reg && range_ok;
  assign do_read  = access && op_rd_reg && !op_wr_reg && range_ok;

  // Next-state and counter logic for the IDLE -> WAIT -> DONE sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Freeze the pipeline while a request is pending. The pipeline is released in DONE and during reset.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i)
      stall_o = ((state_reg == IDLE) && req) || (state_reg == WAIT);
  end

  // Control registers and load data. The operation kind is latched at acceptance,
  // so a request dropped during WAIT still completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      op_wr_reg <= 1'b0;
      op_rd_reg <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req) begin
        op_wr_reg <= MemWrite_i;
        op_rd_reg <= MemRead_i;
      end
      if (do_read)
        rdata_reg <= mem[index];
    end
  end

  assign rdata_o = rdata_reg;

`ifdef DMEM_RANGE_CHECK_EN
  // Sticky out-of-range flag. Only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   err_reg <= 1'b0;
    else if (access && !range_ok) err_reg <= 1'b1;
  end
`endif

  // Memory array write port. It has no reset, so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (do_write)
      mem[index] <= wdata_i;
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl. The driver pushes the expected load data
// and error flag for each request. A negedge monitor measures every stall
// window and, when the window closes, pops the expected values and compares them.
module tb_data_memory_ctrl;
  parameter int LATENCY = 2;
  parameter int ADDR_W  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  data_memory_ctrl #(.LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .MemRead_i (mem_read),
    .MemWrite_i(mem_write),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .stall_o   (stall),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gap;   // required stall-low cycles before this window, -1 = don't care
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act === req_v) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req_v, $time);
  endtask

  // Monitor: measure stall windows and score each one when it closes.
  int run = 0;
  int low = 0;
  int gap_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run = 0;
      low = 0;
    end else if (stall) begin
      if (run == 0) gap_seen = low;
      run++;
    end else if (run > 0) begin
      if (q.size() == 0) begin
        check("unexpected_window", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("rdata", rdata, e.rdata);
        check("stall_len", 32'(run), 32'(LATENCY + 1));
        check("err", {31'd0, err}, {31'd0, e.err});
        if (e.gap >= 0) check("gap", 32'(gap_seen), 32'(e.gap));
        $display("txn done: rdata=0x%08h err=%0b stall=%0d cycles", rdata, err, run);
      end
      run = 0;
      low = 1;
    end else begin
      low++;
    end
  end

  // Issue one request and wait for its window to close. The inputs are left applied afterwards.
  // If drop is set, the request is withdrawn in the first WAIT cycle and wdata becomes drop_data.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input int gap,
                        input bit drop, input logic [31:0] drop_data);
    exp_t e;
    int n = 0;
    bit seen_hi = 0;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    e.rdata = exp_rd; e.err = exp_err; e.gap = gap;
    q.push_back(e);
    if (drop) begin
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      wdata     = drop_data;
      seen_hi   = 1;
    end
    forever begin
      @(negedge clk);
      if (stall) seen_hi = 1;
      else if (seen_hi) break;
      n++;
      if (n > 40) begin
        check("timeout", 32'd1, 32'd0);
        q.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic err_x;

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_req(0, 1, 32'h00, 32'h01020304, 32'h0,        0, -1, 0, 0); idle(2);
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, -1, 0, 0); idle(1);
    do_req(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, -1, 0, 0); idle(1);
    do_req(0, 1, 32'h14, 32'h12345678, 32'hDEADBEEF, 0, -1, 0, 0); idle(1);
    do_req(0, 1, 32'h24, 32'h0BADF00D, 32'hDEADBEEF, 0, -1, 0, 0); idle(1);
    // Back-to-back reads with a single stall-low cycle between the windows.
    do_req(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, -1, 0, 0);
    do_req(1, 0, 32'h14, 32'h0,        32'h12345678, 0,  1, 0, 0); idle(1);
    // A combined read+write is a write, so rdata holds its value.
    do_req(1, 1, 32'h20, 32'hA5A5A5A5, 32'h12345678, 0, -1, 0, 0); idle(1);
    // The byte-offset bits are ignored.
    do_req(1, 0, 32'h22, 32'h0,        32'hA5A5A5A5, 0, -1, 0, 0); idle(1);

    // A reset in the first WAIT cycle aborts the write to 0x24.
    mem_write = 1'b1; addr = 32'h24; wdata = 32'h11111111;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    do_req(1, 0, 32'h24, 32'h0,        32'h0BADF00D, 0, -1, 0, 0); idle(1);

    // Out-of-range write: it aliases to word 0, or sets the sticky error when range checking is on.
    err_x = RC;
    do_req(0, 1, 32'h400, 32'hCAFEF00D, 32'h0BADF00D, err_x, -1, 0, 0); idle(1);
    do_req(1, 0, 32'h00,  32'h0, RC ? 32'h01020304 : 32'hCAFEF00D, err_x, -1, 0, 0); idle(1);

    // The request is dropped during WAIT, and the write takes wdata from the access edge.
    do_req(0, 1, 32'h30, 32'h77777777, RC ? 32'h01020304 : 32'hCAFEF00D, err_x, -1, 1, 32'h88888888);
    idle(1);
    do_req(1, 0, 32'h30, 32'h0,        32'h88888888, err_x, -1, 0, 0); idle(3);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
